sub64_serial: RTL

Multi-cycle subtractor computing D = A − B − Bin over WIDTH bits, DIGIT bits per clock, with a ready/valid handshake on both sides. It sits in the RISC-V datapath beside the ripple adders and reuses the same carry-chain arithmetic in the subtract direction (A + ~B + ~Bin). Operands are captured once and shifted through a DIGIT-wide slice. The block produces the difference plus borrow and signed-overflow flags for SUB/SLT/branch-compare paths.

---
 rtl/sub64_serial_if.sv | 26 ++
 rtl/sub64_serial.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sub64_serial_if.sv
// Operand/result handshake bundle for the serial subtractor.
// master = producer/consumer side, slave = the subtractor.
interface sub64_serial_if #(
    parameter int WIDTH = 64
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             V;

    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, D, Bout, V
    );

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, D, Bout, V
    );
endinterface

// File: rtl/sub64_serial.sv
// Digit-serial subtractor D = A - B - Bin, DIGIT bits per clock, computed as
// A + ~B + ~Bin on a shared carry chain slice; registered ready/valid outputs.
module sub64_serial_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             c_in,
    output logic [DIGIT-1:0] s,
    output logic             c_out
);
    always_comb begin
        {c_out, s} = {1'b0, a} + {1'b0, ~b} + {{DIGIT{1'b0}}, c_in};
    end
endmodule

module sub64_serial #(
    parameter int WIDTH = 64,
    parameter int DIGIT = 4
) (
    input logic            clk,
    input logic            rst,
    sub64_serial_if.slave  bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("sub64_serial: WIDTH must be an integer multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             v_q, v_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [DIGIT-1:0] slice_s;
    logic             slice_c;
    logic [WIDTH-1:0] sd_shift;

    sub64_serial_slice #(.DIGIT(DIGIT)) u_slice (
        .a     (sa_q[DIGIT-1:0]),
        .b     (sb_q[DIGIT-1:0]),
        .c_in  (carry_q),
        .s     (slice_s),
        .c_out (slice_c)
    );

    // Result digits enter at the top so the LSB digit lands at bit 0 after NDIG shifts.
    assign sd_shift = {slice_s, sd_q[WIDTH-1:DIGIT]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        sd_d        = sd_q;
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        d_d         = d_q;
        bout_d      = bout_q;
        v_d         = v_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sa_d       = bus.A;
                    sb_d       = bus.B;
                    a_msb_d    = bus.A[WIDTH-1];
                    b_msb_d    = bus.B[WIDTH-1];
                    carry_d    = ~bus.Bin;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                sa_d    = sa_q >> DIGIT;
                sb_d    = sb_q >> DIGIT;
                sd_d    = sd_shift;
                carry_d = slice_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    d_d         = sd_shift;
                    bout_d      = ~slice_c;
                    v_d         = (a_msb_q != b_msb_q) && (sd_shift[WIDTH-1] != a_msb_q);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            sa_q        <= '0;
            sb_q        <= '0;
            sd_q        <= '0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            d_q         <= '0;
            bout_q      <= 1'b0;
            v_q         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            sd_q        <= sd_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            d_q         <= d_d;
            bout_q      <= bout_d;
            v_q         <= v_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.D         = d_q;
    assign bus.Bout      = bout_q;
    assign bus.V         = v_q;
endmodule
